rr_bus_arbiter: RTL and testbench

RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_priority_encoder.sv | 25 ++
 rtl/rr_bus_arbiter.sv | 79 +++++++
 tb/tb_rr_bus_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants for the round-robin bus arbiter: state encodings and master count.
package arb_pkg;
    localparam int NUM_REQ = 8;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GRANT = 2'b01;
    localparam logic [1:0] TURN  = 2'b10;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/rr_priority_encoder.sv
// Combinational round-robin winner search starting just after the last owner.
module rr_priority_encoder
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         last,
    output logic               found,
    output logic [2:0]         idx
);
    logic [2:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        cand  = 3'd0;
        // Offsets 1..8 wrap naturally in 3 bits; offset 8 revisits last itself.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last + 3'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/rr_bus_arbiter.sv
// Eight-master round-robin bus arbiter with hold limit, turnaround cycle and timeout pulse.
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         sel,
    output logic               busy,
    output logic               timeout
);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    logic [1:0] state;
    logic [7:0] hold_cnt;
    logic [2:0] last;
    logic       found;
    logic [2:0] idx;

    rr_priority_encoder u_enc (
        .req   (req),
        .last  (last),
        .found (found),
        .idx   (idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= 3'd0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= 8'd0;
            last     <= 3'd7;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (found) begin
                        state    <= GRANT;
                        grant    <= onehot(idx);
                        sel      <= idx;
                        last     <= idx;
                        busy     <= 1'b1;
                        hold_cnt <= 8'd0;
                    end
                end
                GRANT: begin
                    hold_cnt <= hold_cnt + 8'd1;
                    // A release coinciding with the limit is a normal release.
                    if (!req[sel]) begin
                        state <= TURN;
                        grant <= '0;
                        busy  <= 1'b0;
                    end else if (hold_cnt == HOLD_LIM) begin
                        state   <= TURN;
                        grant   <= '0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                TURN: begin
                    state   <= IDLE;
                    timeout <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    grant   <= '0;
                    busy    <= 1'b0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: directed vector table, corner sequences, random run against a model.
module tb_rr_bus_arbiter;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       timeout;

    rr_bus_arbiter #(.MAX_HOLD(MH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Behavioural model: who owns the bus, how long, and the turnaround gap.
    int m_owner, m_held, m_last, m_sel, m_gap, m_to;

    task automatic model_reset();
        m_owner = -1; m_held = 0; m_last = 7; m_sel = 0; m_gap = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [7:0] r);
        m_to = 0;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1; m_gap = 1;
            end else if (m_held == MH) begin
                m_owner = -1; m_gap = 1; m_to = 1;
            end else m_held++;
        end else if (m_gap != 0) begin
            m_gap = 0;
        end else if (r != 0) begin
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (m_last + k) % 8;
                if (m_owner < 0 && r[c]) m_owner = c;
            end
            m_last = m_owner; m_sel = m_owner; m_held = 1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [2:0] s;
        logic       b;
        logic       t;
    } vec_t;

    vec_t vt[20];

    initial begin
        logic [7:0] exp_g;
        int         waited;

        vt[0]  = '{8'h04, 8'h04, 3'd2, 1'b1, 1'b0};
        vt[1]  = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
        vt[2]  = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
        vt[3]  = '{8'h00, 8'h00, 3'd2, 1'b0, 1'b0};
        vt[4]  = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
        vt[5]  = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
        vt[6]  = '{8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
        vt[7]  = '{8'h03, 8'h01, 3'd0, 1'b1, 1'b0};
        vt[8]  = '{8'h03, 8'h00, 3'd0, 1'b0, 1'b1};
        vt[9]  = '{8'h03, 8'h00, 3'd0, 1'b0, 1'b0};
        vt[10] = '{8'h03, 8'h02, 3'd1, 1'b1, 1'b0};
        vt[11] = '{8'h02, 8'h02, 3'd1, 1'b1, 1'b0};
        vt[12] = '{8'h02, 8'h02, 3'd1, 1'b1, 1'b0};
        vt[13] = '{8'h02, 8'h02, 3'd1, 1'b1, 1'b0};
        vt[14] = '{8'h00, 8'h00, 3'd1, 1'b0, 1'b0};
        vt[15] = '{8'h00, 8'h00, 3'd1, 1'b0, 1'b0};
        vt[16] = '{8'h41, 8'h40, 3'd6, 1'b1, 1'b0};
        vt[17] = '{8'h00, 8'h00, 3'd6, 1'b0, 1'b0};
        vt[18] = '{8'h00, 8'h00, 3'd6, 1'b0, 1'b0};
        vt[19] = '{8'h41, 8'h01, 3'd0, 1'b1, 1'b0};

        // Reset state, checked while reset is held.
        reset_n = 1'b0;
        #3;
        chk("reset_grant", grant, 0);
        chk("reset_sel", sel, 0);
        chk("reset_busy", busy, 0);
        chk("reset_timeout", timeout, 0);
        do_reset();

        // Directed table: single requester, timeout, limit/release tie, wrap.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req = vt[i].r;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_grant", i), grant, vt[i].g);
            chk($sformatf("vec%0d_sel", i), sel, vt[i].s);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].b);
            chk($sformatf("vec%0d_timeout", i), timeout, vt[i].t);
        end

        // Rotation with all masters requesting, each dropping for one cycle.
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            waited = 0;
            while (grant == 8'h00 && waited < 10) begin
                @(posedge clk);
                #1;
                waited++;
            end
            exp_g = 8'h01 << (k % 8);
            chk($sformatf("rot%0d_grant", k), grant, exp_g);
            chk($sformatf("rot%0d_sel", k), sel, k % 8);
            req = 8'hFF & ~grant;
            @(posedge clk);
            #1;
            req = 8'hFF;
        end

        // Asynchronous reset in the middle of a grant.
        do_reset();
        @(negedge clk);
        req = 8'h08;
        @(posedge clk);
        #1;
        chk("async_pre_grant", grant, 8'h08);
        #2 reset_n = 1'b0;
        #1;
        chk("async_grant", grant, 0);
        chk("async_sel", sel, 0);
        chk("async_busy", busy, 0);
        @(negedge clk);
        req = 8'h81;
        reset_n = 1'b1;
        waited = 0;
        while (grant == 8'h00 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("async_after_grant", grant, 8'h01);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            case ($urandom_range(0, 7))
                0:       req = 8'h00;
                1, 2:    req = 8'($urandom_range(0, 255));
                default: req = req;
            endcase
            @(posedge clk);
            model_step(req);
            #1;
            chk($sformatf("rnd%0d_grant", c), grant, (m_owner >= 0) ? (1 << m_owner) : 0);
            chk($sformatf("rnd%0d_sel", c), sel, m_sel);
            chk($sformatf("rnd%0d_busy", c), busy, (m_owner >= 0) ? 1 : 0);
            chk($sformatf("rnd%0d_timeout", c), timeout, m_to);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
